// File: rtl/block_fill_responder_pkg.sv
// Shared constants and state encoding for the cache line-fill protocol
// (fill FSM, I/D arbitration and memory-side responder).
package block_fill_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2
  } fill_state_e;

  localparam int unsigned ADDR_BITS  = 16;
  localparam int unsigned WORD_BITS  = 16;
  localparam int unsigned LINE_BYTES = 16;
  localparam int unsigned BEATS      = 8;
  localparam int unsigned BEAT_LSB   = 1;
  localparam int unsigned BEAT_BITS  = 3;
  localparam int unsigned LINE_LSB   = 4;
  localparam int unsigned LINE_BITS  = ADDR_BITS - LINE_LSB;

  // Line number of a byte address; the offset within the line is dropped.
  function automatic logic [LINE_BITS-1:0] line_of(input logic [ADDR_BITS-1:0] addr);
    return addr[ADDR_BITS-1:LINE_LSB];
  endfunction

endpackage

// File: rtl/block_fill_responder_mem_array.sv
// fill_mem_array: single-port word RAM with a registered read port.
// Contents have no reset; only the read register clears.
module fill_mem_array
  import block_fill_responder_pkg::*;
#(
  parameter int unsigned WORDS_LOG2 = 10,
  parameter int unsigned WIDTH      = WORD_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic                  re,
  input  logic [WORDS_LOG2-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata
);

  localparam int unsigned DEPTH = 1 << WORDS_LOG2;

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/block_fill_responder.sv
// Memory-side line-fill responder: fixed first-word latency, then an
// eight-beat burst; single-word stores are accepted only while idle.
module block_fill_responder
  import block_fill_responder_pkg::*;
#(
  parameter int unsigned LAT        = 4,
  parameter int unsigned WORDS_LOG2 = 10,
  parameter int unsigned BEATS      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [15:0] req_addr,
  input  logic        wr_en,
  input  logic [15:0] wr_addr,
  input  logic [15:0] wr_data,
  output logic        busy,
  output logic        data_valid,
  output logic [15:0] data_out,
  output logic [15:0] data_addr,
  output logic        wr_ack
);

  localparam int unsigned LAT_W  = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int unsigned BEAT_W = $clog2(BEATS);

  fill_state_e           state;
  fill_state_e           state_next;
  logic [LINE_BITS-1:0]  line;
  logic [LAT_W-1:0]      lat_cnt;
  logic [BEAT_W-1:0]     beat;

  logic                  wr_go_c;
  logic                  accept_c;
  logic                  rd_go_c;
  logic [WORDS_LOG2-1:0] mem_addr_c;

  // Offset bits that never reach storage.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[LINE_LSB-1:0], wr_addr[0],
                              wr_addr[ADDR_BITS-1:WORDS_LOG2+1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // beat wraps to 0 after beat 7 is read, which marks the end of the burst.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (accept_c) state_next = ST_WAIT;
      ST_WAIT:  if (lat_cnt == '0) state_next = ST_BURST;
      ST_BURST: if (beat == '0) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // A store in IDLE has priority over a fill request on the same edge.
  always_comb begin
    wr_go_c    = 1'b0;
    accept_c   = 1'b0;
    rd_go_c    = 1'b0;
    mem_addr_c = WORDS_LOG2'({line, beat});
    case (state)
      ST_IDLE: begin
        wr_go_c  = wr_en;
        accept_c = req && !wr_en;
      end
      ST_WAIT:  rd_go_c = (lat_cnt == '0);
      ST_BURST: rd_go_c = (beat != '0);
      default: ;
    endcase
    if (wr_go_c) begin
      mem_addr_c = WORDS_LOG2'(wr_addr[WORDS_LOG2:1]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      line    <= '0;
      lat_cnt <= '0;
      beat    <= '0;
    end else begin
      if (accept_c) begin
        line    <= line_of(req_addr);
        lat_cnt <= LAT_W'(LAT - 1);
        beat    <= '0;
      end else if (state == ST_WAIT && lat_cnt != '0) begin
        lat_cnt <= lat_cnt - LAT_W'(1);
      end
      if (rd_go_c) begin
        beat <= beat + BEAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      data_valid <= 1'b0;
      data_addr  <= '0;
      wr_ack     <= 1'b0;
    end else begin
      busy       <= (state_next != ST_IDLE);
      data_valid <= rd_go_c;
      wr_ack     <= wr_go_c;
      if (rd_go_c) begin
        data_addr <= {line, beat, 1'b0};
      end
    end
  end

  fill_mem_array #(
    .WORDS_LOG2 (WORDS_LOG2),
    .WIDTH      (WORD_BITS)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_go_c && rst_n),
    .re    (rd_go_c),
    .addr  (mem_addr_c),
    .wdata (wr_data),
    .rdata (data_out)
  );

endmodule

// File: tb/tb_block_fill_responder.sv
// Scoreboard bench for block_fill_responder: expected beats come from a
// local word model and are popped as data_valid beats appear.
module tb_block_fill_responder;

  localparam int LAT = 4;

  typedef struct packed {
    logic        chk;
    logic [15:0] addr;
    logic [15:0] data;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [15:0] req_addr;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;
  logic        busy;
  logic        data_valid;
  logic [15:0] data_out;
  logic [15:0] data_addr;
  logic        wr_ack;

  int    total = 0;
  int    bad   = 0;
  beat_t sb[$];
  logic [15:0] model [1024];
  bit          known [1024];

  int start0, start1, got;
  bit ack_seen;

  block_fill_responder #(.LAT(LAT), .WORDS_LOG2(10), .BEATS(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_addr   (req_addr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .data_valid (data_valid),
    .data_out   (data_out),
    .data_addr  (data_addr),
    .wr_ack     (wr_ack)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_line(input logic [15:0] a);
    beat_t e;
    logic [15:0] ba;
    for (int b = 0; b < 8; b++) begin
      ba     = {a[15:4], 3'(b), 1'b0};
      e.chk  = known[ba[10:1]];
      e.addr = ba;
      e.data = model[ba[10:1]];
      sb.push_back(e);
    end
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
    model[a[10:1]] = d;
    known[a[10:1]] = 1'b1;
    total++;
    if (wr_ack !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL write_ack addr=%h: wr_ack=%b busy=%b, required 1/0", a, wr_ack, busy);
    end
    tick();
    total++;
    if (wr_ack !== 1'b0) begin
      bad++;
      $display("FAIL write_ack_pulse addr=%h: wr_ack=%b, required 0", a, wr_ack);
    end
  endtask

  task automatic fill_req(input logic [15:0] a);
    req = 1'b1; req_addr = a;
    tick();
    req = 1'b0;
    push_line(a);
    total++;
    if (busy !== 1'b1 || data_valid !== 1'b0) begin
      bad++;
      $display("FAIL accept addr=%h: busy=%b data_valid=%b, required 1/0", a, busy, data_valid);
    end
  endtask

  // Counts edges from the acceptance edge (n=0); beats must be contiguous
  // within each line.
  task automatic collect(input int nbeats, input int poke_n, input int drop_req_n);
    int    n;
    beat_t e;
    n = 0; got = 0; start0 = -1; start1 = -1; ack_seen = 1'b0;
    while (got < nbeats && n < 2 * LAT + 40) begin
      tick();
      n++;
      if (wr_ack) ack_seen = 1'b1;
      if (data_valid) begin
        if (got == 0) start0 = n;
        if (got == 8) start1 = n;
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL beat%0d: unexpected data_valid addr=%h", got, data_addr);
        end else begin
          e = sb.pop_front();
          if ((e.chk && data_out !== e.data) || data_addr !== e.addr || busy !== 1'b1 ||
              n != ((got < 8) ? start0 : start1) + (got % 8)) begin
            bad++;
            $display("FAIL beat%0d: data=%h addr=%h busy=%b edge=%0d, required data=%h addr=%h busy=1",
                     got, data_out, data_addr, busy, n, e.data, e.addr);
          end
        end
        got++;
      end
      if (n == poke_n) begin
        wr_en = 1'b1; wr_addr = 16'h0012; wr_data = 16'hDEAD;
      end else begin
        wr_en = 1'b0;
      end
      if (n == drop_req_n) req = 1'b0;
    end
    wr_en = 1'b0;
    if (got < nbeats) begin
      total++;
      bad++;
      $display("FAIL burst_timeout: got %0d beats, required %0d", got, nbeats);
    end
  endtask

  task automatic check_idle_after(input string name);
    tick();
    total++;
    if (busy !== 1'b0 || data_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s: busy=%b data_valid=%b, required 0/0", name, busy, data_valid);
    end
  endtask

  task automatic check_start(input string name, input int seen, input int want);
    total++;
    if (seen != want) begin
      bad++;
      $display("FAIL %s: first beat at edge %0d, required %0d", name, seen, want);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i == 2) rst_n = 1'b1;
      tick();
      total++;
      if (busy !== 1'b0 || data_valid !== 1'b0 || wr_ack !== 1'b0 || data_out !== 16'h0000) begin
        bad++;
        $display("FAIL reset_idle cycle%0d: busy=%b valid=%b ack=%b data=%h, required 0/0/0/0000",
                 i, busy, data_valid, wr_ack, data_out);
      end
    end
  endtask

  task automatic test_write_fill;
    for (int i = 0; i < 8; i++) begin
      do_write(16'h0010 + 16'(2 * i), 16'h1111 * 16'(i + 1));
    end
    fill_req(16'h001F);
    collect(8, -1, -1);
    check_start("write_fill_latency", start0, LAT);
    check_idle_after("write_fill_busy_fall");
  endtask

  task automatic test_collision;
    wr_en = 1'b1; wr_addr = 16'h0020; wr_data = 16'hBEEF;
    req = 1'b1; req_addr = 16'h0020;
    tick();
    wr_en = 1'b0;
    model[16'h0010] = 16'hBEEF;
    known[16'h0010] = 1'b1;
    total++;
    if (wr_ack !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL collision_write: wr_ack=%b busy=%b, required 1/0", wr_ack, busy);
    end
    fill_req(16'h0020);
    total++;
    if (wr_ack !== 1'b0) begin
      bad++;
      $display("FAIL collision_ack_pulse: wr_ack=%b, required 0", wr_ack);
    end
    collect(8, -1, -1);
    check_start("collision_latency", start0, LAT);
    check_idle_after("collision_end");
  endtask

  task automatic test_write_busy;
    fill_req(16'h0010);
    collect(8, LAT + 1, -1);
    total++;
    if (ack_seen) begin
      bad++;
      $display("FAIL busy_write_ack: wr_ack=1 seen during burst, required 0");
    end
    check_idle_after("busy_write_end");
    fill_req(16'h0010);
    collect(8, -1, -1);
    check_start("busy_write_refill", start0, LAT);
    check_idle_after("busy_write_refill_end");
  endtask

  task automatic test_reset_mid_burst;
    fill_req(16'h0010);
    collect(3, -1, -1);
    rst_n = 1'b0;
    tick();
    total++;
    if (data_valid !== 1'b0 || busy !== 1'b0 || data_out !== 16'h0000) begin
      bad++;
      $display("FAIL mid_reset: valid=%b busy=%b data=%h, required 0/0/0000", data_valid, busy, data_out);
    end
    rst_n = 1'b1;
    sb.delete();
    tick();
    fill_req(16'h0010);
    collect(8, -1, -1);
    check_start("mid_reset_refill", start0, LAT);
    check_idle_after("mid_reset_refill_end");
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 8; i++) begin
      do_write(16'(2 * i), 16'hA000 + 16'(i));
    end
    req = 1'b1; req_addr = 16'h0000;
    tick();
    req_addr = 16'h0010;
    push_line(16'h0000);
    push_line(16'h0010);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_accept: busy=%b, required 1", busy);
    end
    collect(16, -1, LAT + 9);
    req = 1'b0;
    check_start("b2b_first", start0, LAT);
    check_start("b2b_second", start1, 2 * LAT + 9);
    check_idle_after("b2b_end");
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; req_addr = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    test_reset();
    test_write_fill();
    test_collision();
    test_write_busy();
    test_reset_mid_burst();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
